// File: rtl/apb_pkg.sv
// Shared types and sizing helpers for the APB master.
// Imported by the controller and its response mux.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DERR
  } state_t;

  localparam int APB_PROT_W = 3;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/apb_rsp_mux.sv
// Picks the addressed slave's PRDATA/PREADY/PSLVERR.
// Out-of-range indices yield all zeros.
module apb_rsp_mux
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SLAVES_NUM = 2,
  parameter int IDX_W      = idx_w(SLAVES_NUM)
) (
  input  logic [IDX_W-1:0]                 idx,
  input  logic [SLAVES_NUM*DATA_WIDTH-1:0] prdata,
  input  logic [SLAVES_NUM-1:0]            pready,
  input  logic [SLAVES_NUM-1:0]            pslverr,
  output logic [DATA_WIDTH-1:0]            sel_rdata,
  output logic                             sel_ready,
  output logic                             sel_err
);

  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int i = 0; i < SLAVES_NUM; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_rdata = prdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_ready = pready[i];
        sel_err   = pslverr[i];
      end
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB4 master: request port to multi-slave APB bus with
// address decode, wait-state timeout and one response per request.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SLAVES_NUM     = 2,
  parameter int SEL_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic                             req_write,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  input  logic [strb_w(DATA_WIDTH)-1:0]    req_strb,
  input  logic [APB_PROT_W-1:0]            req_prot,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             rsp_timeout,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [SLAVES_NUM-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [strb_w(DATA_WIDTH)-1:0]    PSTRB,
  output logic [APB_PROT_W-1:0]            PPROT,
  input  logic [SLAVES_NUM*DATA_WIDTH-1:0] PRDATA,
  input  logic [SLAVES_NUM-1:0]            PREADY,
  input  logic [SLAVES_NUM-1:0]            PSLVERR
);

  localparam int IDX_W = idx_w(SLAVES_NUM);
  localparam int CNT_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t                state;
  state_t                state_nxt;
  logic [IDX_W-1:0]      idx;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] dec;
  logic                  dec_ok;
  logic                  accept;
  logic                  done;
  logic                  tmo;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  sel_ready;
  logic                  sel_err;

  apb_rsp_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .SLAVES_NUM (SLAVES_NUM),
    .IDX_W      (IDX_W)
  ) u_rsp_mux (
    .idx       (idx),
    .prdata    (PRDATA),
    .pready    (PREADY),
    .pslverr   (PSLVERR),
    .sel_rdata (sel_rdata),
    .sel_ready (sel_ready),
    .sel_err   (sel_err)
  );

  // Whole field above SEL_LSB must be in range; aliases are decode errors.
  assign dec    = req_addr >> SEL_LSB;
  assign dec_ok = dec < ADDR_WIDTH'(SLAVES_NUM);

  assign tmo = (TIMEOUT_CYCLES != 0) && !sel_ready &&
               (cnt == CNT_W'(TIMEOUT_CYCLES));
  assign done = (state == ACCESS) && (sel_ready || tmo);

  assign req_ready = (state == IDLE) || done;
  assign accept    = req_valid && req_ready;
  assign PENABLE   = (state == ACCESS);

  always_comb begin
    PSEL = '0;
    if (state == SETUP || state == ACCESS) begin
      for (int i = 0; i < SLAVES_NUM; i++) begin
        PSEL[i] = (idx == IDX_W'(i));
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = dec_ok ? SETUP : DERR;
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (done) begin
          if (!accept)     state_nxt = IDLE;
          else if (dec_ok) state_nxt = SETUP;
          else             state_nxt = DERR;
        end
      end
      DERR:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      // SETUP always precedes ACCESS, so the count starts at zero
      cnt <= (state == ACCESS && !sel_ready) ? cnt + CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      idx    <= '0;
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      PSTRB  <= '0;
      PPROT  <= '0;
    end else if (accept) begin
      idx    <= dec[IDX_W-1:0];
      PADDR  <= req_addr;
      PWRITE <= req_write;
      PWDATA <= req_wdata;
      PSTRB  <= req_write ? req_strb : '0;
      PPROT  <= req_prot;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (done) begin
        rsp_valid   <= 1'b1;
        rsp_err     <= sel_ready ? sel_err : 1'b1;
        rsp_timeout <= !sel_ready;
        rsp_rdata   <= (sel_ready && !PWRITE && !sel_err)
                       ? sel_rdata : '0;
      end else if (state == DERR) begin
        rsp_valid   <= 1'b1;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b0;
        rsp_rdata   <= '0;
      end
    end
  end

endmodule
